// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

   // Default register-address width (16 architectural registers).
   localparam int REG_AW_DEF = 4;

   // Destination field width inside a scoreboard entry. Register addresses
   // are zero-extended into it, so any REG_AW up to this width is supported.
   localparam int SB_DEST_W = 16;

   // Operand-select encoding: 0 reads the register file, k>0 forwards from
   // in-flight stage k (1=MEM ... DEPTH-1=WB).
   localparam int SEL_RF = 0;

   typedef struct packed {
      logic                 valid;
      logic                 wb_en;
      logic                 mem_r;
      logic [SB_DEST_W-1:0] dest;
   } sb_entry_t;

   localparam sb_entry_t SB_BUBBLE = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: counts qualifying cycles and holds at all-ones.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] r_count;

   // Count up on inc, stop at all-ones so the value never wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (inc && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, stall and forwarding-select generation for the ID stage.
// A scoreboard shift register mirrors the instructions in flight after ID
// (entry 0 = EXE ... entry DEPTH-1 = WB).
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF,
   parameter int DEPTH  = 3,
   parameter int FWD_EN = 1,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     id_valid,
   input  logic [REG_AW-1:0]        id_src1,
   input  logic [REG_AW-1:0]        id_src2,
   input  logic                     id_two_src,
   input  logic                     id_wb_en,
   input  logic                     id_mem_r_en,
   input  logic [REG_AW-1:0]        id_dest,
   input  logic                     flush,
   output logic                     stall,
   output logic [$clog2(DEPTH)-1:0] fwd_sel1,
   output logic [$clog2(DEPTH)-1:0] fwd_sel2,
   output logic [CNT_W-1:0]         stall_cnt,
   output logic [CNT_W-1:0]         flush_cnt
);

   localparam int SEL_W = $clog2(DEPTH);

   sb_entry_t        r_sb [DEPTH];
   logic [SEL_W-1:0] r_sel1;
   logic [SEL_W-1:0] r_sel2;

   // Entry DEPTH-1 (WB) is never compared: the register file writes before
   // it is read, so the ID stage already sees that result.
   logic [DEPTH-2:0] w_m1;
   logic [DEPTH-2:0] w_m2;
   logic             w_hazard;
   logic             w_stall;
   logic             w_issue;
   logic [SEL_W-1:0] w_sel1_nxt;
   logic [SEL_W-1:0] w_sel2_nxt;
   sb_entry_t        w_id_entry;

   // Compare each used source against every producer still ahead of WB.
   always_comb begin
      w_m1 = '0;
      w_m2 = '0;
      for (int k = 0; k < DEPTH - 1; k++) begin
         w_m1[k] = id_valid & r_sb[k].valid & r_sb[k].wb_en &
                   (r_sb[k].dest == SB_DEST_W'(id_src1));
         w_m2[k] = id_valid & id_two_src & r_sb[k].valid & r_sb[k].wb_en &
                   (r_sb[k].dest == SB_DEST_W'(id_src2));
      end
   end

   // With forwarding only a load still in EXE blocks issue; without it any
   // pending producer does. Flush always wins over a stall.
   always_comb begin
      w_hazard = 1'b0;
      if (FWD_EN != 0) begin
         w_hazard = (w_m1[0] | w_m2[0]) & r_sb[0].mem_r;
      end else begin
         w_hazard = (|w_m1) | (|w_m2);
      end
      w_stall = w_hazard & ~flush;
      w_issue = id_valid & ~w_stall & ~flush;
   end

   // Pick the youngest matching producer: scan oldest to youngest so the
   // lowest index overwrites.
   always_comb begin
      w_sel1_nxt = SEL_W'(SEL_RF);
      w_sel2_nxt = SEL_W'(SEL_RF);
      if ((FWD_EN != 0) && w_issue) begin
         for (int k = DEPTH - 2; k >= 0; k--) begin
            if (w_m1[k]) w_sel1_nxt = SEL_W'(k + 1);
            if (w_m2[k]) w_sel2_nxt = SEL_W'(k + 1);
         end
      end
   end

   // Entry captured into EXE when the ID instruction issues.
   always_comb begin
      w_id_entry       = SB_BUBBLE;
      w_id_entry.valid = 1'b1;
      w_id_entry.wb_en = id_wb_en;
      w_id_entry.mem_r = id_mem_r_en;
      w_id_entry.dest  = SB_DEST_W'(id_dest);
   end

   // Advance the scoreboard and register the EXE operand selects.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) r_sb[k] <= SB_BUBBLE;
         r_sel1 <= SEL_W'(SEL_RF);
         r_sel2 <= SEL_W'(SEL_RF);
      end else begin
         r_sb[0] <= w_issue ? w_id_entry : SB_BUBBLE;
         for (int k = 1; k < DEPTH; k++) r_sb[k] <= r_sb[k-1];
         r_sel1 <= w_sel1_nxt;
         r_sel2 <= w_sel2_nxt;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_stall),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush),
      .count (flush_cnt)
   );

   assign stall    = w_stall;
   assign fwd_sel1 = r_sel1;
   assign fwd_sel2 = r_sel2;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: one forwarding instance (default widths) and one
// stall-only instance with a 2-bit counter to reach saturation quickly.
module tb_pipe_hazard_ctrl;

   typedef struct packed {
      logic       rst;
      logic       valid;
      logic [3:0] s1;
      logic [3:0] s2;
      logic       two;
      logic       wb;
      logic       mr;
      logic [3:0] dest;
      logic       fl;
   } in_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   in_t a_in;
   in_t b_in;

   logic        a_stall, b_stall;
   logic [1:0]  a_sel1, a_sel2, b_sel1, b_sel2;
   logic [15:0] a_scnt, a_fcnt;
   logic [1:0]  b_scnt, b_fcnt;

   int total = 0;
   int bad   = 0;
   logic [3:0] exp_q [$];

   pipe_hazard_ctrl #(.REG_AW(4), .DEPTH(3), .FWD_EN(1), .CNT_W(16)) u_fwd (
      .clk         (clk),
      .rst         (a_in.rst),
      .id_valid    (a_in.valid),
      .id_src1     (a_in.s1),
      .id_src2     (a_in.s2),
      .id_two_src  (a_in.two),
      .id_wb_en    (a_in.wb),
      .id_mem_r_en (a_in.mr),
      .id_dest     (a_in.dest),
      .flush       (a_in.fl),
      .stall       (a_stall),
      .fwd_sel1    (a_sel1),
      .fwd_sel2    (a_sel2),
      .stall_cnt   (a_scnt),
      .flush_cnt   (a_fcnt)
   );

   pipe_hazard_ctrl #(.REG_AW(4), .DEPTH(3), .FWD_EN(0), .CNT_W(2)) u_stl (
      .clk         (clk),
      .rst         (b_in.rst),
      .id_valid    (b_in.valid),
      .id_src1     (b_in.s1),
      .id_src2     (b_in.s2),
      .id_two_src  (b_in.two),
      .id_wb_en    (b_in.wb),
      .id_mem_r_en (b_in.mr),
      .id_dest     (b_in.dest),
      .flush       (b_in.fl),
      .stall       (b_stall),
      .fwd_sel1    (b_sel1),
      .fwd_sel2    (b_sel2),
      .stall_cnt   (b_scnt),
      .flush_cnt   (b_fcnt)
   );

   function automatic in_t mk(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                              input logic two, input logic wb, input logic mr,
                              input logic [3:0] d, input logic fl, input logic rs);
      in_t x;
      x.rst = rs; x.valid = v; x.s1 = s1; x.s2 = s2; x.two = two;
      x.wb = wb; x.mr = mr; x.dest = d; x.fl = fl;
      return x;
   endfunction

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive one ID cycle on instance b=0 (fwd) or b=1 (stall-only): check the
   // combinational stall mid-cycle, then the registered selects after the edge.
   task automatic step(input string tag, input bit b, input in_t x,
                       input logic exp_st, input logic [1:0] e1, input logic [1:0] e2);
      logic [3:0] e;
      if (b) b_in = x; else a_in = x;
      exp_q.push_back({e1, e2});
      @(negedge clk);
      chk({tag, ".stall"}, 16'(b ? b_stall : a_stall), 16'(exp_st));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk({tag, ".sel1"}, 16'(b ? b_sel1 : a_sel1), 16'(e[3:2]));
      chk({tag, ".sel2"}, 16'(b ? b_sel2 : a_sel2), 16'(e[1:0]));
   endtask

   initial begin
      a_in = mk(1, 4'd1, 4'd2, 1, 1, 1, 4'd1, 1, 1);
      b_in = mk(1, 4'd1, 4'd2, 1, 1, 1, 4'd1, 1, 1);
      repeat (2) @(posedge clk);
      #1;
      chk("rst.a_sel1", 16'(a_sel1), 16'd0);
      chk("rst.a_sel2", 16'(a_sel2), 16'd0);
      chk("rst.a_scnt", a_scnt, 16'd0);
      chk("rst.a_fcnt", a_fcnt, 16'd0);
      chk("rst.b_scnt", 16'(b_scnt), 16'd0);
      chk("rst.b_fcnt", 16'(b_fcnt), 16'd0);
      b_in = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Forwarding instance
      step("a1",  0, mk(1, 4'd5,  4'd6, 1, 1, 0, 4'd1,  0, 0), 0, 0, 0);
      step("a2",  0, mk(1, 4'd1,  4'd0, 0, 1, 0, 4'd3,  0, 0), 0, 1, 0);
      step("a3",  0, mk(1, 4'd7,  4'd8, 1, 1, 0, 4'd9,  0, 0), 0, 0, 0);
      step("a4",  0, mk(1, 4'd12, 4'd0, 0, 1, 0, 4'd11, 0, 0), 0, 0, 0);
      step("a5",  0, mk(1, 4'd9,  4'd0, 0, 1, 0, 4'd12, 0, 0), 0, 2, 0);
      step("a6",  0, mk(1, 4'd9,  4'd0, 0, 1, 0, 4'd12, 0, 0), 0, 0, 0);
      step("a7",  0, mk(1, 4'd12, 4'd0, 0, 1, 0, 4'd13, 0, 0), 0, 1, 0);
      step("a8",  0, mk(1, 4'd14, 4'd0, 0, 1, 1, 4'd2,  0, 0), 0, 0, 0);
      step("a9",  0, mk(1, 4'd0,  4'd2, 1, 1, 0, 4'd3,  0, 0), 1, 0, 0);
      step("a10", 0, mk(1, 4'd0,  4'd2, 1, 1, 0, 4'd3,  0, 0), 0, 0, 2);
      chk("a.scnt_loaduse", a_scnt, 16'd1);
      step("a11", 0, mk(1, 4'd0,  4'd0, 0, 1, 1, 4'd5,  0, 0), 0, 0, 0);
      step("a12", 0, mk(1, 4'd6,  4'd5, 0, 1, 0, 4'd7,  0, 0), 0, 0, 0);
      step("a13", 0, mk(1, 4'd0,  4'd0, 0, 1, 1, 4'd8,  0, 0), 0, 0, 0);
      step("a14", 0, mk(1, 4'd8,  4'd0, 0, 1, 1, 4'd8,  1, 0), 0, 0, 0);
      step("a15", 0, mk(1, 4'd8,  4'd0, 0, 0, 0, 4'd0,  0, 0), 0, 2, 0);
      chk("a.fcnt", a_fcnt, 16'd1);
      chk("a.scnt", a_scnt, 16'd1);
      step("a16", 0, mk(1, 4'd0,  4'd0, 0, 1, 1, 4'd4,  0, 0), 0, 0, 0);
      step("a17", 0, mk(1, 4'd4,  4'd0, 0, 1, 0, 4'd5,  0, 1), 1, 0, 0);
      chk("a.scnt_after_rst", a_scnt, 16'd0);
      chk("a.fcnt_after_rst", a_fcnt, 16'd0);
      step("a18", 0, mk(1, 4'd4,  4'd0, 0, 1, 0, 4'd5,  0, 0), 0, 0, 0);
      a_in = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Stall-only instance
      step("b1",  1, mk(1, 4'd5, 4'd0, 0, 1, 0, 4'd1, 0, 0), 0, 0, 0);
      step("b2",  1, mk(1, 4'd1, 4'd0, 0, 1, 0, 4'd2, 0, 0), 1, 0, 0);
      step("b3",  1, mk(1, 4'd1, 4'd0, 0, 1, 0, 4'd2, 0, 0), 1, 0, 0);
      step("b4",  1, mk(1, 4'd1, 4'd0, 0, 1, 0, 4'd2, 0, 0), 0, 0, 0);
      chk("b.scnt2", 16'(b_scnt), 16'd2);
      step("b5",  1, mk(1, 4'd0, 4'd2, 1, 1, 0, 4'd3, 0, 0), 1, 0, 0);
      step("b6",  1, mk(1, 4'd0, 4'd2, 1, 1, 0, 4'd3, 0, 0), 1, 0, 0);
      step("b7",  1, mk(1, 4'd0, 4'd2, 1, 1, 0, 4'd3, 0, 0), 0, 0, 0);
      chk("b.scnt_sat", 16'(b_scnt), 16'd3);
      for (int i = 0; i < 5; i++) begin
         step("bfl", 1, mk(0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 1, 0), 0, 0, 0);
      end
      chk("b.fcnt_sat", 16'(b_fcnt), 16'd3);
      chk("b.scnt_hold", 16'(b_scnt), 16'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
